// File: rtl/loader_pkg.sv
// Shared types and default constants for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [1:0] {
        LD_COLLECT,
        LD_WRITE,
        LD_DONE
    } ld_state_e;

    localparam logic [31:0] TERM_WORD_DEFAULT   = 32'hFFFF_FFFF;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 1_000_000;

endpackage

// File: rtl/uart_imem_loader_if.sv
// UART byte stream in, imem write port and load status out.
interface uart_imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);

    logic              uart_rx_valid;
    logic [7:0]        uart_rx_data;
    logic              uart_rx_break;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              write_done;
    logic              core_resetn;
    logic [ADDR_W:0]   word_count;

    modport master (
        input  uart_rx_valid, uart_rx_data, uart_rx_break,
        output imem_we, imem_addr, imem_wdata, write_done, core_resetn, word_count
    );

    modport slave (
        output uart_rx_valid, uart_rx_data, uart_rx_break,
        input  imem_we, imem_addr, imem_wdata, write_done, core_resetn, word_count
    );

endinterface

// File: rtl/byte_packer.sv
// Packs bytes little-endian into a 32-bit word; break or inter-byte timeout drops a partial word.
module byte_packer
    import loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_break,
    output logic        word_ready,
    output logic [31:0] word
);

    localparam int unsigned   TimerW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYC);

    logic [1:0]        byte_cnt_q;
    logic [31:0]       word_q;
    logic [TimerW-1:0] timer_q;
    logic              accept;

    // Break has priority over a byte arriving in the same cycle.
    assign accept     = en && rx_valid && !rx_break;
    assign word_ready = accept && (byte_cnt_q == 2'd3);

    // Word as it would look with the incoming byte placed in its lane.
    always_comb begin
        word = word_q;
        unique case (byte_cnt_q)
            2'd0: word[7:0]   = rx_data;
            2'd1: word[15:8]  = rx_data;
            2'd2: word[23:16] = rx_data;
            2'd3: word[31:24] = rx_data;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_cnt_q <= 2'd0;
            word_q     <= 32'h0;
            timer_q    <= '0;
        end else if (en && rx_break) begin
            byte_cnt_q <= 2'd0;
            word_q     <= 32'h0;
            timer_q    <= '0;
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_q     <= (byte_cnt_q == 2'd3) ? 32'h0 : word;
            timer_q    <= '0;
        end else if (byte_cnt_q != 2'd0) begin
            if (timer_q == TimerMax) begin
                byte_cnt_q <= 2'd0;
                word_q     <= 32'h0;
                timer_q    <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Writes UART-received words sequentially into imem, holding the core in reset until done.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MAX_WORDS   = 256,
    parameter logic [31:0] TERM_WORD   = TERM_WORD_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input logic                clk,
    input logic                resetn,
    uart_imem_loader_if.master bus
);

    localparam logic [ADDR_W:0] MaxCount = (ADDR_W + 1)'(MAX_WORDS);

    ld_state_e         state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              done_q;
    logic              core_resetn_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_inc;
    logic              word_ready;
    logic [31:0]       word;

    assign count_inc = count_q + 1'b1;

    byte_packer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_packer (
        .clk       (clk),
        .resetn    (resetn),
        .en        (state_q == LD_COLLECT),
        .rx_valid  (bus.uart_rx_valid),
        .rx_data   (bus.uart_rx_data),
        .rx_break  (bus.uart_rx_break),
        .word_ready(word_ready),
        .word      (word)
    );

    // The write/terminator decision is registered on the edge that takes the
    // 4th byte, so imem_we and write_done appear in the following cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= LD_COLLECT;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= 32'h0;
            done_q        <= 1'b0;
            core_resetn_q <= 1'b0;
            count_q       <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                LD_COLLECT: begin
                    if (word_ready) begin
                        state_q <= LD_WRITE;
                        if (word == TERM_WORD) begin
                            done_q        <= 1'b1;
                            core_resetn_q <= 1'b1;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= count_q[ADDR_W-1:0];
                            wdata_q <= word;
                        end
                    end
                end
                LD_WRITE: begin
                    if (done_q) begin
                        state_q <= LD_DONE;
                    end else begin
                        count_q <= count_inc;
                        if (count_inc == MaxCount) begin
                            done_q        <= 1'b1;
                            core_resetn_q <= 1'b1;
                            state_q       <= LD_DONE;
                        end else begin
                            state_q <= LD_COLLECT;
                        end
                    end
                end
                LD_DONE: ;
                default: state_q <= LD_COLLECT;
            endcase
        end
    end

    assign bus.imem_we     = we_q;
    assign bus.imem_addr   = addr_q;
    assign bus.imem_wdata  = wdata_q;
    assign bus.write_done  = done_q;
    assign bus.core_resetn = core_resetn_q;
    assign bus.word_count  = count_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench: a default-capacity loader and a two-word loader, both with a short timeout.
module tb_uart_imem_loader;

    logic clk;
    logic resetn;

    int checks;
    int errors;

    // Writes observed per DUT since last reset, plus the latest one.
    int          wr0;
    int          wr1;
    logic [7:0]  last_addr0;
    logic [31:0] last_data0;
    logic [7:0]  last_addr1;
    logic [31:0] last_data1;

    uart_imem_loader_if #(.ADDR_W(8)) bus0 ();
    uart_imem_loader_if #(.ADDR_W(8)) bus1 ();

    uart_imem_loader #(
        .ADDR_W     (8),
        .MAX_WORDS  (256),
        .TERM_WORD  (32'hFFFF_FFFF),
        .TIMEOUT_CYC(100)
    ) dut0 (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus0)
    );

    uart_imem_loader #(
        .ADDR_W     (8),
        .MAX_WORDS  (2),
        .TERM_WORD  (32'hFFFF_FFFF),
        .TIMEOUT_CYC(100)
    ) dut1 (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!resetn) begin
            wr0 = 0;
            wr1 = 0;
        end else begin
            if (bus0.imem_we) begin
                wr0++;
                last_addr0 = bus0.imem_addr;
                last_data0 = bus0.imem_wdata;
            end
            if (bus1.imem_we) begin
                wr1++;
                last_addr1 = bus1.imem_addr;
                last_data1 = bus1.imem_wdata;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input int which, input logic [7:0] b);
        if (which == 0) begin
            bus0.uart_rx_valid = 1'b1;
            bus0.uart_rx_data  = b;
        end else begin
            bus1.uart_rx_valid = 1'b1;
            bus1.uart_rx_data  = b;
        end
        @(posedge clk);
        #1;
        bus0.uart_rx_valid = 1'b0;
        bus1.uart_rx_valid = 1'b0;
    endtask

    // Returns one #1 after the edge that samples the 4th byte.
    task automatic send_word(input int which, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            idle(3);
            send_byte(which, w[8*i +: 8]);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " we"},          {63'h0, bus0.imem_we},     64'h0);
        check({tag, " addr"},        {56'h0, bus0.imem_addr},   64'h0);
        check({tag, " wdata"},       {32'h0, bus0.imem_wdata},  64'h0);
        check({tag, " write_done"},  {63'h0, bus0.write_done},  64'h0);
        check({tag, " core_resetn"}, {63'h0, bus0.core_resetn}, 64'h0);
        check({tag, " word_count"},  {55'h0, bus0.word_count},  64'h0);
    endtask

    typedef struct {
        logic [31:0] word;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [8:0]  exp_count;
        logic        exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin
        checks = 0;
        errors = 0;
        wr0 = 0;
        wr1 = 0;
        last_addr0 = '0;
        last_data0 = '0;
        last_addr1 = '0;
        last_data1 = '0;
        bus0.uart_rx_valid = 1'b0;
        bus0.uart_rx_data  = 8'h0;
        bus0.uart_rx_break = 1'b0;
        bus1.uart_rx_valid = 1'b0;
        bus1.uart_rx_data  = 8'h0;
        bus1.uart_rx_break = 1'b0;

        vecs[0] = '{32'hFD01_0113, 1'b1, 8'd0, 9'd1, 1'b0};
        vecs[1] = '{32'h0281_2623, 1'b1, 8'd1, 9'd2, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 8'd0, 9'd2, 1'b1};
        vecs[3] = '{32'h1234_5678, 1'b0, 8'd0, 9'd2, 1'b1};

        do_reset();
        check_reset_vals("reset");

        // Program, terminator, then a word that must be ignored in DONE.
        for (int i = 0; i < 4; i++) begin
            send_word(0, vecs[i].word);
            check($sformatf("v%0d we", i), {63'h0, bus0.imem_we}, {63'h0, vecs[i].exp_we});
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d addr", i), {56'h0, bus0.imem_addr}, {56'h0, vecs[i].exp_addr});
                check($sformatf("v%0d wdata", i), {32'h0, bus0.imem_wdata}, {32'h0, vecs[i].word});
            end
            check($sformatf("v%0d done", i), {63'h0, bus0.write_done}, {63'h0, vecs[i].exp_done});
            check($sformatf("v%0d core_resetn", i), {63'h0, bus0.core_resetn},
                  {63'h0, vecs[i].exp_done});
            idle(1);
            check($sformatf("v%0d we one cycle", i), {63'h0, bus0.imem_we}, 64'h0);
            check($sformatf("v%0d count", i), {55'h0, bus0.word_count}, {55'h0, vecs[i].exp_count});
        end
        idle(2);
        check("program writes", 64'(wr0), 64'd2);

        // Break discards a partial word.
        do_reset();
        send_byte(0, 8'h13);
        idle(2);
        send_byte(0, 8'h01);
        bus0.uart_rx_break = 1'b1;
        idle(1);
        bus0.uart_rx_break = 1'b0;
        send_word(0, 32'h0281_2623);
        idle(2);
        check("break writes", 64'(wr0), 64'd1);
        check("break addr", {56'h0, last_addr0}, 64'h0);
        check("break data", {32'h0, last_data0}, 64'h0281_2623);

        // Break and byte together: byte dropped, partial cleared.
        do_reset();
        send_byte(0, 8'h13);
        idle(2);
        bus0.uart_rx_break = 1'b1;
        send_byte(0, 8'h55);
        bus0.uart_rx_break = 1'b0;
        send_word(0, 32'h0281_2623);
        idle(2);
        check("brk+valid writes", 64'(wr0), 64'd1);
        check("brk+valid data", {32'h0, last_data0}, 64'h0281_2623);

        // Gap shorter than the timeout keeps the partial word.
        do_reset();
        send_byte(0, 8'hAA);
        idle(50);
        send_byte(0, 8'h01);
        idle(3);
        send_byte(0, 8'h01);
        idle(3);
        send_byte(0, 8'hFD);
        idle(2);
        check("short gap writes", 64'(wr0), 64'd1);
        check("short gap data", {32'h0, last_data0}, 64'hFD01_01AA);

        // Gap longer than the timeout discards it.
        do_reset();
        send_byte(0, 8'hAA);
        idle(150);
        send_word(0, 32'hFD01_0113);
        idle(2);
        check("timeout writes", 64'(wr0), 64'd1);
        check("timeout addr", {56'h0, last_addr0}, 64'h0);
        check("timeout data", {32'h0, last_data0}, 64'hFD01_0113);

        // Reset in the middle of a word.
        do_reset();
        send_byte(0, 8'h13);
        idle(2);
        send_byte(0, 8'h01);
        idle(1);
        resetn = 1'b0;
        #2;
        check_reset_vals("mid reset");
        idle(2);
        resetn = 1'b1;
        idle(1);
        check("mid reset no write", 64'(wr0), 64'd0);
        send_word(0, 32'h0281_2623);
        check("post reset we", {63'h0, bus0.imem_we}, 64'h1);
        check("post reset addr", {56'h0, bus0.imem_addr}, 64'h0);
        check("post reset data", {32'h0, bus0.imem_wdata}, 64'h0281_2623);

        // Two-word memory fills, third word ignored.
        do_reset();
        send_word(1, 32'h0000_0011);
        send_word(1, 32'h0000_0022);
        check("full we", {63'h0, bus1.imem_we}, 64'h1);
        check("full done early", {63'h0, bus1.write_done}, 64'h0);
        idle(1);
        check("full done", {63'h0, bus1.write_done}, 64'h1);
        check("full core_resetn", {63'h0, bus1.core_resetn}, 64'h1);
        check("full count", {55'h0, bus1.word_count}, 64'd2);
        send_word(1, 32'h0000_0033);
        idle(3);
        check("full writes", 64'(wr1), 64'd2);
        check("full last addr", {56'h0, last_addr1}, 64'd1);
        check("full last data", {32'h0, last_data1}, 64'h22);
        check("full count after", {55'h0, bus1.word_count}, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
